// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO multi-cycle divider.
package hilo_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Quotient reported for a divide by zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/hilo_div_unit_signfix.sv
// Two-lane conditional two's-complement negate. Used to take magnitudes of the
// operands on the way in and to restore signs on quotient/remainder on the way out.
module div_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg_a,
  input  logic [WIDTH-1:0] b,
  input  logic             neg_b,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  // Negation wraps modulo 2**WIDTH, so the most negative value maps to itself.
  assign a_out = neg_a ? ((~a) + WIDTH'(1)) : a;
  assign b_out = neg_b ? ((~b) + WIDTH'(1)) : b;

endmodule

// File: rtl/hilo_div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU, producing {hi=remainder, lo=quotient}.
// Optional build macro HILO_DIV_FAST_PATH_EN: when defined, a divide by zero or a
// dividend magnitude smaller than the divisor magnitude skips iteration and
// completes in the cycle after start.
module hilo_div_unit
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] ZERO_LO  = WIDTH'(DIV_ZERO_LO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, dvsr;
  logic             quot_neg, rem_neg, div_zero;

  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH:0]   trial, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, quot_step, rem_fix, quot_fix;
  logic             accept, last_iter, fast;

  div_signfix #(.WIDTH(WIDTH)) u_opnd (
    .a     (dividend),
    .neg_a (signed_op & dividend[WIDTH-1]),
    .b     (divisor),
    .neg_b (signed_op & divisor[WIDTH-1]),
    .a_out (abs_dividend),
    .b_out (abs_divisor)
  );

  // One restoring step: shift the next dividend bit into the WIDTH+1 bit
  // partial remainder and keep the subtraction only if it did not go negative.
  assign trial     = {rem, quot[WIDTH-1]};
  assign diff      = trial - {1'b0, dvsr};
  assign qbit      = ~diff[WIDTH];
  assign rem_step  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_step = {quot[WIDTH-2:0], qbit};

  div_signfix #(.WIDTH(WIDTH)) u_res (
    .a     (quot_step),
    .neg_a (quot_neg),
    .b     (rem_step),
    .neg_b (rem_neg),
    .a_out (quot_fix),
    .b_out (rem_fix)
  );

  assign accept    = (state == IDLE) & start & ~cancel;
  assign last_iter = (state == BUSY) && (cnt == LAST_CNT);
  assign busy      = (state != IDLE);
  assign valid     = (state == DONE);

`ifdef HILO_DIV_FAST_PATH_EN
  assign fast = (divisor == '0) || (abs_dividend < abs_divisor);
`else
  assign fast = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; cancel aborts from any state and wins over start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fast ? DONE : BUSY;
      BUSY:    if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cancel) state_next = IDLE;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else if (accept) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= abs_dividend;
      dvsr     <= abs_divisor;
      quot_neg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      rem_neg  <= signed_op & dividend[WIDTH-1];
      div_zero <= (divisor == '0);
`ifdef HILO_DIV_FAST_PATH_EN
      if (fast) begin
        hi <= dividend;
        lo <= (divisor == '0) ? ZERO_LO : '0;
      end
`endif
    end else if ((state == BUSY) && !cancel) begin
      rem  <= rem_step;
      quot <= quot_step;
      cnt  <= cnt + CNT_W'(1);
      if (last_iter) begin
        hi <= rem_fix;
        lo <= div_zero ? ZERO_LO : quot_fix;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit (default and fast-path builds).
module tb_hilo_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

`ifdef HILO_DIV_FAST_PATH_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = 33;
`endif

  hilo_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .valid     (valid),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a divide in the current cycle and wait (bounded) for valid.
  // reassert_at > 0 pulses start with junk operands in that cycle while busy.
  task automatic do_div(input string tag, input logic sop, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int reassert_at);
    int n;
    bit seen;
    int busy_low;
    start = 1'b1; signed_op = sop; dividend = a; divisor = b;
    n = 0; seen = 1'b0; busy_low = 0;
    while (!seen && n < 60) begin
      step();
      n++;
      start = (n == reassert_at);
      if (start) begin
        signed_op = 1'b0; dividend = 32'd1; divisor = 32'd1;
      end
      if (valid) seen = 1'b1;
      else if (!busy) busy_low++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_window"}, 64'(busy_low), 64'd0);
    check({tag, "_busy_at_valid"}, {63'd0, busy}, 64'd1);
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
  endtask

  // Cycle after valid: back in IDLE with valid dropped.
  task automatic after_done(input string tag);
    step();
    check({tag, "_valid_drop"}, {63'd0, valid}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) step();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_valid", {63'd0, valid}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;
    step();
    check("idle_busy", {63'd0, busy}, 64'd0);

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 0);
    after_done("divu_100_7");
    do_div("divu_ffffffff_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF, 0);
    after_done("divu_ffffffff_16");
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    after_done("div_m7_2");
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 0);
    after_done("div_7_m2");
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 0);
    after_done("div_min_m1");
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, LAT_SHORT, 32'hFFFF_FFFF, 32'd5, 0);
    after_done("divu_5_0");
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, LAT_SHORT, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
    after_done("div_m5_0");

    // Cancel at T+10: idle at T+11, no valid, results untouched.
    start = 1'b1; signed_op = 1'b0; dividend = 32'd200; divisor = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      step();
      start = 1'b0;
    end
    check("cancel_busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy_after", {63'd0, busy}, 64'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid) vcount++;
    end
    check("cancel_no_valid", 64'(vcount), 64'd0);
    check("cancel_hi_kept", {32'd0, hi}, {32'd0, 32'hFFFF_FFFB});
    check("cancel_lo_kept", {32'd0, lo}, {32'd0, 32'hFFFF_FFFF});

    // Cancel in IDLE overrides start.
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3;
    step();
    start = 1'b0; cancel = 1'b0;
    check("cancel_over_start", {63'd0, busy}, 64'd0);

    // Start ignored while busy; latency and result unchanged.
    do_div("divu_reassert", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 5);
    after_done("divu_reassert");

    // Reset at T+20 clears everything on the next edge.
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    for (int i = 1; i <= 20; i++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_valid", {63'd0, valid}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    step();

    // Back-to-back: second start in the cycle right after valid.
    do_div("b2b_first", 1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0, 0);
    after_done("b2b_first");
    do_div("b2b_second", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
    after_done("b2b_second");

    // Small-dividend cases: early completion only with the fast path built in.
    do_div("divu_3_9", 1'b0, 32'd3, 32'd9, LAT_SHORT, 32'd0, 32'd3, 0);
    after_done("divu_3_9");
    do_div("div_m3_9", 1'b1, 32'hFFFF_FFFD, 32'd9, LAT_SHORT, 32'd0, 32'hFFFF_FFFD, 0);
    after_done("div_m3_9");
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 0);
    after_done("divu_9_3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
